// File: rtl/cpu7_exu_ldsb.sv
// Load scoreboard: tracks up to DEPTH in-order outstanding loads and stalls
// decode only on RAW/WAW against a pending load or when the queue is full.
module cpu7_exu_ldsb #(
    parameter int DEPTH = 4,
    parameter int NREG  = 32,
    parameter int RA_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid_d,
    input  logic                       ld_issue_d,
    input  logic [RA_W-1:0]            rd_d,
    input  logic                       wen_d,
    input  logic [RA_W-1:0]            rs1_d,
    input  logic                       rs1_en_d,
    input  logic [RA_W-1:0]            rs2_d,
    input  logic                       rs2_en_d,
    input  logic                       ld_ret_m,
    input  logic [RA_W-1:0]            ld_ret_rd_m,
    input  logic                       flush,
    output logic                       stall_req,
    output logic [$clog2(DEPTH):0]     pend_cnt,
    output logic                       empty,
    output logic                       full,
    output logic [NREG-1:0]            pend_mask,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr, wr_ptr_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [DEPTH-1:0] vld_q, vld_n;
    logic [DEPTH-1:0] wen_q, wen_n;
    logic [RA_W-1:0] rd_q [DEPTH];
    logic [RA_W-1:0] rd_n [DEPTH];
    logic [NREG-1:0] mask_q, mask_n, eff_mask;
    logic            err_q, err_n;

    logic [RA_W-1:0] head_rd;
    logic            head_wen;
    logic            other_match;
    logic            raw1, raw2, waw, ovf;
    logic            push, pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign pend_cnt  = cnt_q;
    assign pend_mask = mask_q;
    assign err       = err_q;

    assign head_rd  = rd_q[rd_ptr];
    assign head_wen = vld_q[rd_ptr] & wen_q[rd_ptr];

    // Detect whether any younger pending load targets the same register as the head
    always_comb begin
        other_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i) != rd_ptr && vld_q[i] && wen_q[i] && rd_q[i] == head_rd)
                other_match = 1'b1;
        end
    end

    // Release the returning head's register in the same cycle unless a younger load still owns it
    always_comb begin
        eff_mask = mask_q;
        if (ld_ret_m && !empty && head_wen && !other_match)
            eff_mask[head_rd] = 1'b0;
    end

    assign raw1 = rs1_en_d & eff_mask[rs1_d];
    assign raw2 = rs2_en_d & eff_mask[rs2_d];
    assign waw  = wen_d & eff_mask[rd_d];
    assign ovf  = ld_issue_d & full & ~ld_ret_m;

    assign stall_req = instr_valid_d & ~flush & (raw1 | raw2 | waw | ovf);
    assign push      = instr_valid_d & ld_issue_d & ~stall_req & ~flush;
    assign pop       = ld_ret_m & ~empty & ~flush;

    // Next queue state: flush wipes everything, otherwise pop frees the head before push fills the tail
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        cnt_n    = cnt_q;
        vld_n    = vld_q;
        wen_n    = wen_q;
        rd_n     = rd_q;
        err_n    = err_q;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            cnt_n    = '0;
            vld_n    = '0;
        end else begin
            if (ld_ret_m && empty)
                err_n = 1'b1;
            if (pop) begin
                if (head_wen && ld_ret_rd_m != head_rd)
                    err_n = 1'b1;
                vld_n[rd_ptr] = 1'b0;
                rd_ptr_n      = rd_ptr + PW'(1);
            end
            if (push) begin
                vld_n[wr_ptr] = 1'b1;
                rd_n[wr_ptr]  = rd_d;
                wen_n[wr_ptr] = wen_d & (rd_d != '0);
                wr_ptr_n      = wr_ptr + PW'(1);
            end
            if (push && !pop)
                cnt_n = cnt_q + CW'(1);
            else if (pop && !push)
                cnt_n = cnt_q - CW'(1);
        end
    end

    // Pending-write bitmap rebuilt from the next-state entries so it is registered alongside them
    always_comb begin
        mask_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_n[i] && wen_n[i])
                mask_n[rd_n[i]] = 1'b1;
        end
        mask_n[0] = 1'b0;
    end

    // State register with asynchronous reset; outstanding loads are forgotten on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
            wen_q  <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                rd_q[i] <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            cnt_q  <= cnt_n;
            vld_q  <= vld_n;
            wen_q  <= wen_n;
            mask_q <= mask_n;
            err_q  <= err_n;
            rd_q   <= rd_n;
        end
    end

endmodule

// File: doc/cpu7_exu_ldsb.md
Name: cpu7_exu_ldsb

Overview:
- Parametrised load scoreboard for the EXU control path.
- Replaces the single-load "stall until rdata returns" scheme with up to DEPTH in-order outstanding loads.
- Tracks each load's destination register in a FIFO.
- Requests a decode stall only on a true hazard: RAW or WAW against a pending load, or FIFO full.
- Sits between decode dispatch and the LSU return path; its stall output is ORed into the IFU stall request.

Parameters:
- DEPTH, 4, maximum outstanding loads (power of two, >=2)
- NREG, 32, architectural GPR count
- RA_W, 5, register address width (log2 NREG)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_valid_d  in  1  valid instruction in decode
- ld_issue_d  in  1  decode instruction is a load (qualified by instr_valid_d)
- rd_d  in  RA_W  destination of the decode instruction
- wen_d  in  1  decode instruction writes rd_d
- rs1_d  in  RA_W  source 1 address
- rs1_en_d  in  1  source 1 is read
- rs2_d  in  RA_W  source 2 address
- rs2_en_d  in  1  source 2 is read
- ld_ret_m  in  1  LSU load data returning this cycle (in order)
- ld_ret_rd_m  in  RA_W  rd of the returning load
- flush  in  1  pipeline flush; LSU cancels all outstanding loads in the same cycle
- stall_req  out  1  combinational stall of decode
- pend_cnt  out  log2(DEPTH)+1  registered count of outstanding loads
- empty  out  1  pend_cnt==0
- full  out  1  pend_cnt==DEPTH
- pend_mask  out  NREG  registered bitmap of registers with a pending load write
- err  out  1  sticky protocol error

Behaviour:
- Entry format: {rd, wen}. Circular FIFO with rd/wr pointers, DEPTH entries.
- Reset (async, rst=1) state:
  - pointers = 0, pend_cnt = 0, empty = 1, full = 0, pend_mask = 0, err = 0.
  - stall_req follows its combinational equation with these state values.
- pend_mask bit r is 1 iff some valid entry has wen=1 and rd=r, r!=0. Bit 0 is always 0.
- Return-bypassed mask (eff_mask): pend_mask with head rd cleared when ld_ret_m=1. The bit is cleared only if no other valid entry targets the same rd.
- Hazards, each requiring instr_valid_d=1:
  - raw1 = rs1_en_d & eff_mask[rs1_d]
  - raw2 = rs2_en_d & eff_mask[rs2_d]
  - waw = wen_d & eff_mask[rd_d]
  - ovf = ld_issue_d & full & ~ld_ret_m
- stall_req = instr_valid_d & ~flush & (raw1 | raw2 | waw | ovf).
- Push: instr_valid_d & ld_issue_d & ~stall_req & ~flush writes {rd_d, wen_d & (rd_d!=0)} at the wr pointer. A load with wen=0 is still pushed so return ordering is preserved.
- Pop: ld_ret_m & ~empty & ~flush advances the rd pointer.
- Push and pop in the same cycle:
  - pend_cnt is unchanged.
  - Legal when full, because pop frees the slot first.
- Return checks:
  - If the head entry has wen=1 and ld_ret_rd_m != head rd, set err. The pop still occurs.
  - ld_ret_m while empty: ignored, sets err.
- flush, highest priority:
  - Next state: pointers = 0, pend_cnt = 0, pend_mask = 0.
  - push and pop are suppressed that cycle.
  - err is not cleared. Only rst clears err.
- Latency:
  - A pushed load appears in pend_mask and pend_cnt on the next edge.
  - A returning load's hazard is released in the same cycle through eff_mask (zero-bubble load-use after return).
- Pointer wrap: rd and wr wrap modulo DEPTH. full/empty are derived from pend_cnt, not pointer compare.
- rst mid-operation: all state returns to reset values immediately. Outstanding loads are forgotten.

Test Plan:
- Issue load rd=5, then a dependent instruction with rs1=5 -> stall_req=1 until the cycle ld_ret_m=1 with ld_ret_rd_m=5; stall_req=0 in that cycle; pend_mask[5]=0 afterwards.
- Issue 4 loads (rd=1,2,3,4) back to back with DEPTH=4 -> pend_cnt=4, full=1. A 5th load stalls; the same 5th load with simultaneous ld_ret_m (rd=1) issues, and pend_cnt stays 4.
- Two pending loads to rd=7, return the first -> pend_mask[7] stays 1. A reader of r7 still stalls until the second return.
- Load to rd=0 and load with wen_d=0 -> pushed, pend_cnt increments, pend_mask unchanged. A reader of r0 never stalls.
- 3 outstanding loads then flush=1 -> next cycle pend_cnt=0, empty=1, pend_mask=0. A subsequent ld_ret_m -> err=1, which stays 1 until rst.
- Head rd=9, return with ld_ret_rd_m=10 -> err=1 and pend_cnt decrements. Async rst pulse mid-stream -> all outputs return to reset values without waiting for a clk edge.
